// File: rtl/crc_rx_pkg.sv
// Shared types and constants for the bit-serial CRC receiver/checker.
package crc_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } crc_rx_state_t;

   localparam logic [16:0] DEFAULT_POLY = 17'h1_8005;

endpackage

// File: rtl/crc_rx_check_lfsr.sv
// Combinational one-bit CRC LFSR update (non-reflected, MSB-first); shared with the generator side.
module crc_lfsr_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] r,
   input  logic             b,
   input  logic [WIDTH-1:0] poly,
   output logic [WIDTH-1:0] r_next
);

   logic fb_s;

   assign fb_s   = r[WIDTH-1] ^ b;
   assign r_next = {r[WIDTH-2:0], 1'b0} ^ ({WIDTH{fb_s}} & poly);

endmodule

// File: rtl/crc_rx_check.sv
// Bit-serial CRC receiver: shifts in WIDTH data bits then WIDTH CRC bits and flags OK on a zero remainder.
// Optional error counter port err_cnt_o enabled by defining CRC_RX_ERRCNT_EN.
module crc_rx_check
   import crc_rx_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(2*WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH:0]   polynom_i,
   input  logic             start_i,
   input  logic             bit_i,
   input  logic             bit_valid_i,
   output logic [WIDTH-1:0] data_o,
   output logic [WIDTH-1:0] crc_rx_o,
   output logic             OK,
   output logic             out_ready_CRC,
   output logic             busy_o
`ifdef CRC_RX_ERRCNT_EN
   ,
   output logic [7:0]       err_cnt_o
`endif
);

   crc_rx_state_t      state_r, state_s;
   logic [WIDTH-1:0]   rem_r, rem_base_s, rem_step_s;
   logic [WIDTH-1:0]   poly_r, poly_base_s;
   logic [CNT_W-1:0]   cnt_r, cnt_base_s;
   logic [2*WIDTH-1:0] frame_r, frame_base_s, frame_step_s;
   logic               restart_s, active_s, acc_s, last_s;
   logic               busy_s, ready_s;
   logic               poly_unused_s;

   // The x^WIDTH term is implicit in the shift and never enters the update.
   assign poly_unused_s = polynom_i[WIDTH];

   // Acceptance qualifiers; a start (outside DONE) restarts from a clean remainder and counter.
   always_comb begin
      restart_s = start_i && (state_r != DONE);
      active_s  = restart_s || (state_r == DATA) || (state_r == CHECK);
      acc_s     = active_s && bit_valid_i;
      if (restart_s) begin
         rem_base_s   = '0;
         poly_base_s  = polynom_i[WIDTH-1:0];
         cnt_base_s   = '0;
         frame_base_s = '0;
      end else begin
         rem_base_s   = rem_r;
         poly_base_s  = poly_r;
         cnt_base_s   = cnt_r;
         frame_base_s = frame_r;
      end
      last_s       = acc_s && (cnt_base_s == CNT_W'(2*WIDTH-1));
      frame_step_s = {frame_base_s[2*WIDTH-2:0], bit_i};
   end

   crc_lfsr_step #(.WIDTH(WIDTH)) u_step (
      .r      (rem_base_s),
      .b      (bit_i),
      .poly   (poly_base_s),
      .r_next (rem_step_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= IDLE;
      else      state_r <= state_s;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE, DATA, CHECK: begin
            if (last_s)                                          state_s = DONE;
            else if (acc_s && (cnt_base_s >= CNT_W'(WIDTH-1)))   state_s = CHECK;
            else if (restart_s)                                  state_s = DATA;
            else                                                 state_s = state_r;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Output decode from the upcoming state so the registered flags line up with it.
   always_comb begin
      busy_s  = (state_s == DATA) || (state_s == CHECK);
      ready_s = (state_s == DONE);
   end

   // Remainder, counter, polynomial and frame shift register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_r   <= '0;
         poly_r  <= '0;
         cnt_r   <= '0;
         frame_r <= '0;
      end else begin
         poly_r <= poly_base_s;
         if (acc_s) begin
            rem_r   <= rem_step_s;
            cnt_r   <= cnt_base_s + CNT_W'(1);
            frame_r <= frame_step_s;
         end else begin
            rem_r   <= rem_base_s;
            cnt_r   <= cnt_base_s;
            frame_r <= frame_base_s;
         end
      end
   end

   // Result registers load as the final bit is taken, so they are valid during DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_o        <= '0;
         crc_rx_o      <= '0;
         OK            <= 1'b0;
         out_ready_CRC <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         out_ready_CRC <= ready_s;
         busy_o        <= busy_s;
         if (ready_s) begin
            data_o   <= frame_step_s[2*WIDTH-1:WIDTH];
            crc_rx_o <= frame_step_s[WIDTH-1:0];
            OK       <= (rem_step_s == '0);
         end else begin
            data_o   <= data_o;
            crc_rx_o <= crc_rx_o;
            OK       <= OK;
         end
      end
   end

`ifdef CRC_RX_ERRCNT_EN
   // Saturating count of frames that finished with a non-zero remainder.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                                      err_cnt_o <= 8'h00;
      else if (ready_s && (rem_step_s != '0) && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 8'd1;
      else                                                           err_cnt_o <= err_cnt_o;
   end
`endif

endmodule

// File: tb/tb_crc_rx_check.sv
// Directed self-checking bench for crc_rx_check (WIDTH=16, poly 0x8005); checks err_cnt_o when CRC_RX_ERRCNT_EN is defined.
module tb_crc_rx_check;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] polynom_i;
   logic        start_i, bit_i, bit_valid_i;
   logic [15:0] data_o, crc_rx_o;
   logic        OK, out_ready_CRC, busy_o;
`ifdef CRC_RX_ERRCNT_EN
   logic [7:0]  err_cnt_o;
`endif

   int checks    = 0;
   int failures  = 0;
   int pulse_cnt = 0;
   int p0;
   bit busy_bad;

   crc_rx_check #(.WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .polynom_i     (polynom_i),
      .start_i       (start_i),
      .bit_i         (bit_i),
      .bit_valid_i   (bit_valid_i),
      .data_o        (data_o),
      .crc_rx_o      (crc_rx_o),
      .OK            (OK),
      .out_ready_CRC (out_ready_CRC),
      .busy_o        (busy_o)
`ifdef CRC_RX_ERRCNT_EN
      ,
      .err_cnt_o     (err_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Count cycles in which the ready pulse is high.
   always @(posedge clk) begin
      if (out_ready_CRC === 1'b1) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic v, input logic b);
      @(negedge clk);
      start_i     = s;
      bit_valid_i = v;
      bit_i       = b;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) drive(i == 0, 1'b1, w[31-i]);
   endtask

   // Full frame; returns at the falling edge inside the DONE cycle.
   task automatic send_frame(input logic [31:0] w, input bit gap, input bit chg_poly);
      for (int i = 0; i < 32; i++) begin
         drive(i == 0, 1'b1, w[31-i]);
         if (i > 0 && busy_o !== 1'b1) busy_bad = 1'b1;
         if (i == 1 && chg_poly) polynom_i = 17'h1_1021;
         if (gap && i < 31) begin
            drive(1'b0, 1'b0, ~w[31-i]);
            if (busy_o !== 1'b1) busy_bad = 1'b1;
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      polynom_i = 17'h1_8005;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; start_i = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0;
      polynom_i = 17'h1_8005; busy_bad = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_data",  32'(data_o),        32'h0);
      check("rst_crc",   32'(crc_rx_o),      32'h0);
      check("rst_ok",    32'(OK),            32'h0);
      check("rst_ready", 32'(out_ready_CRC), 32'h0);
      check("rst_busy",  32'(busy_o),        32'h0);
`ifdef CRC_RX_ERRCNT_EN
      check("rst_err",   32'(err_cnt_o),     32'h0);
`endif
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);

      // Good frame.
      send_frame(32'hAAFF_FE08, 1'b0, 1'b0);
      check("good_ready", 32'(out_ready_CRC), 32'h1);
      check("good_data",  32'(data_o),        32'hAAFF);
      check("good_crc",   32'(crc_rx_o),      32'hFE08);
      check("good_ok",    32'(OK),            32'h1);
      drive(1'b0, 1'b0, 1'b0);
      check("good_pulse_width", 32'(out_ready_CRC), 32'h0);
      check("good_busy_after",  32'(busy_o),        32'h0);

      // Corrupt frame: data bit 3 flipped.
      send_frame(32'hAAF7_FE08, 1'b0, 1'b0);
      check("bad_ready", 32'(out_ready_CRC), 32'h1);
      check("bad_data",  32'(data_o),        32'hAAF7);
      check("bad_ok",    32'(OK),            32'h0);
`ifdef CRC_RX_ERRCNT_EN
      check("bad_err",   32'(err_cnt_o),     32'h1);
`endif
      repeat (3) drive(1'b0, 1'b1, 1'b1);
      check("idle_hold_data", 32'(data_o),        32'hAAF7);
      check("idle_busy",      32'(busy_o),        32'h0);
      check("idle_ready",     32'(out_ready_CRC), 32'h0);

      // Gapped valid, polynomial input changed mid-frame.
      busy_bad = 1'b0;
      send_frame(32'hAAFF_FE08, 1'b1, 1'b1);
      check("gap_ready", 32'(out_ready_CRC), 32'h1);
      check("gap_data",  32'(data_o),        32'hAAFF);
      check("gap_crc",   32'(crc_rx_o),      32'hFE08);
      check("gap_ok",    32'(OK),            32'h1);
      check("gap_busy",  32'(busy_bad),      32'h0);

      // Abort after 10 bits and restart with a good frame.
      drive(1'b0, 1'b0, 1'b0);
      p0 = pulse_cnt;
      send_bits(32'h1234_5678, 10);
      send_frame(32'hAAFF_FE08, 1'b0, 1'b0);
      check("abort_data", 32'(data_o), 32'hAAFF);
      check("abort_ok",   32'(OK),     32'h1);
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      check("abort_pulses", 32'(pulse_cnt - p0), 32'd1);

      // Reset after bit 20.
      p0 = pulse_cnt;
      send_bits(32'hAAFF_FE08, 21);
      @(negedge clk);
      rst = 1'b0; start_i = 1'b0; bit_valid_i = 1'b0;
      #1;
      check("mrst_data",  32'(data_o),        32'h0);
      check("mrst_crc",   32'(crc_rx_o),      32'h0);
      check("mrst_ok",    32'(OK),            32'h0);
      check("mrst_busy",  32'(busy_o),        32'h0);
      check("mrst_ready", 32'(out_ready_CRC), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      check("mrst_pulses", 32'(pulse_cnt - p0), 32'd0);
      send_frame(32'hAAFF_FE08, 1'b0, 1'b0);
      check("mrst_next_ok",   32'(OK),     32'h1);
      check("mrst_next_data", 32'(data_o), 32'hAAFF);
`ifdef CRC_RX_ERRCNT_EN
      check("mrst_err", 32'(err_cnt_o), 32'h0);
`endif

      // Back-to-back frames.
      drive(1'b0, 1'b0, 1'b0);
      p0 = pulse_cnt;
      send_frame(32'hAAFF_FE08, 1'b0, 1'b0);
      check("b2b_ready1", 32'(out_ready_CRC), 32'h1);
      send_frame(32'h0000_0000, 1'b0, 1'b0);
      check("b2b_ready2", 32'(out_ready_CRC), 32'h1);
      check("b2b_data2",  32'(data_o),        32'h0);
      check("b2b_crc2",   32'(crc_rx_o),      32'h0);
      check("b2b_ok2",    32'(OK),            32'h1);
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      check("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crc_rx_check.md
Name: crc_rx_check

Overview:
- Bit-serial CRC receiver/checker; receive-side counterpart of the parallel CRC generator.
- Accepts a codeword MSB-first: WIDTH data bits, then WIDTH transmitted CRC bits.
- Recovers the data word and transmitted CRC, and flags the frame OK when the running remainder is zero.
- Sits between the serial line deserialiser and the frame consumer.

Parameters:
- WIDTH, 16, data word width and CRC width in bits.
- CNT_W, $clog2(2*WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset; 0 clears all state.
- polynom_i  input  WIDTH+1  generator polynomial including x^WIDTH term, e.g. 17'h1_8005; sampled on accepted start.
- start_i  input  1  frame start; the bit on bit_i in the same cycle is frame bit 0 when bit_valid_i=1.
- bit_i  input  1  serial codeword bit, MSB first.
- bit_valid_i  input  1  bit_i is valid this cycle; gaps allowed.
- data_o  output  WIDTH  received data word.
- crc_rx_o  output  WIDTH  received CRC field.
- OK  output  1  1 when the last frame's remainder was 0.
- out_ready_CRC  output  1  one-cycle pulse; data_o/crc_rx_o/OK are valid.
- busy_o  output  1  frame in progress.

Behaviour:
- Reset values: all outputs 0; state IDLE; remainder 0; counter 0; latched polynomial 0.
- CRC algorithm: non-reflected, init 0, no final XOR.
  - Per accepted bit b: fb = r[WIDTH-1]^b; r = {r[WIDTH-2:0],1'b0} ^ (fb ? poly[WIDTH-1:0] : 0).
  - poly[WIDTH] is ignored.
- States: IDLE, DATA, CHECK, DONE.
- IDLE:
  - start_i=1 latches polynom_i, clears r and the counter, and enters DATA.
  - If bit_valid_i=1 in the same cycle, that bit is consumed as bit 0.
- DATA:
  - Each valid bit shifts into the data shift register and the LFSR; counter increments.
  - After bit WIDTH-1 is consumed, go to CHECK.
- CHECK:
  - Each valid bit shifts into the CRC shift register and the LFSR.
  - After bit 2*WIDTH-1 is consumed, go to DONE.
- DONE (one cycle):
  - data_o, crc_rx_o and OK = (r==0) update registered.
  - out_ready_CRC=1; then return to IDLE.
- Latency: out_ready_CRC is asserted the cycle after the final bit is accepted.
- busy_o = 1 in DATA and CHECK.
- Outputs hold their values until the next DONE.
- start_i while busy_o=1 aborts the current frame and restarts as in IDLE; no out_ready_CRC for the aborted frame.
- start_i in DONE is ignored (treated as IDLE start next cycle only if still asserted).
- bit_valid_i in IDLE without start_i: ignored.
- Reset mid-frame: immediate clear; the partial frame is discarded.
- polynom_i changes mid-frame have no effect.

Optional Feature:
- Macro CRC_RX_ERRCNT_EN.
- With it:
  - Adds port err_cnt_o output 8.
  - Increments in DONE when OK=0, saturating at 8'hFF.
  - Reset to 0 only by rst.
- Without it: port and counter absent; the rest is identical.

Decomposition:
- Package crc_rx_pkg:
  - state enum type crc_rx_state_t {IDLE, DATA, CHECK, DONE}.
  - localparam DEFAULT_POLY = 17'h1_8005.
- Sub-module crc_lfsr_step: combinational one-bit LFSR update (r, b, poly -> r_next), parameterised by WIDTH.
  - Reusable by the generator side.

Test Plan:
- Good frame: WIDTH=16, poly 17'h1_8005, start, then bits 0xAAFF followed by 0xFE08, continuous valid.
  - Expect out_ready_CRC pulse 1 cycle after bit 31, data_o=16'hAAFF, crc_rx_o=16'hFE08, OK=1.
- Corrupt frame: same, but flip data bit 3 (0xAAF7).
  - Expect OK=0, data_o=16'hAAF7; with CRC_RX_ERRCNT_EN, err_cnt_o=1.
- Gapped valid: same good frame with bit_valid_i low every other cycle.
  - Expect identical outputs; pulse 1 cycle after last valid bit; busy_o high throughout.
- Abort: start a frame, after 10 bits reassert start_i and send the good frame.
  - Expect exactly one out_ready_CRC, OK=1, data_o=16'hAAFF.
- Reset mid-frame: drive rst=0 after bit 20 for 2 cycles.
  - Expect all outputs 0 and busy_o=0 immediately; no pulse; a following good frame passes.
- Back-to-back: start_i asserted the cycle after DONE with the next frame (0x0000, CRC 0x0000).
  - Expect two pulses; second has data_o=0, OK=1.
